and_check_engine: RTL and testbench

//  Synthesizable self-checking stimulus/compare engine for the AND datapath under test (c = a & b).

---
 rtl/and_chk_pkg.sv | 15 +
 rtl/and_check_engine_if.sv | 26 ++
 rtl/and_chk_lfsr.sv | 21 ++
 rtl/and_check_engine.sv | 160 ++++++++++++++++
 tb/tb_and_check_engine.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/and_chk_pkg.sv
// Shared state encoding, LFSR polynomial/seed and the LFSR step function
// used by the AND check engine.
package and_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [31:0] CHK_LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] CHK_SEED_DEFAULT = 32'h0000_ACE1;

    // Right-shifting Galois form: the bit shifted out selects the tap mask.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? CHK_LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/and_check_engine_if.sv
// Operand/result and run-control bundle between the check engine and its host/DUT.
// first_err exists only when CHK_FIRST_ERR_EN is defined.
interface and_check_engine_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [ERR_CNT_W-1:0] err_cnt;

`ifdef CHK_FIRST_ERR_EN
    logic [3*WIDTH-1:0]   first_err;

    modport master (input start, c, output a, b, busy, done, pass, err_cnt, first_err);
    modport slave  (output start, c, input a, b, busy, done, pass, err_cnt, first_err);
`else
    modport master (input start, c, output a, b, busy, done, pass, err_cnt);
    modport slave  (output start, c, input a, b, busy, done, pass, err_cnt);
`endif

endinterface

// File: rtl/and_chk_lfsr.sv
// 32-bit Galois LFSR vector source; reset and load both restore SEED.
module and_chk_lfsr
    import and_chk_pkg::*;
#(
    parameter logic [31:0] SEED = CHK_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (rst || load)
            state <= SEED;
        else if (advance)
            state <= lfsr_step(state);
    end

endmodule

// File: rtl/and_check_engine.sv
// Self-checking stimulus/compare engine for an AND datapath (c = a & b).
// Optional CHK_FIRST_ERR_EN adds capture of {a,b,c} for the first mismatch of a run.
module and_check_engine
    import and_chk_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          NUM_VECTORS = 256,
    parameter int          DUT_LATENCY = 1,
    parameter int          ERR_CNT_W   = 8,
    parameter logic [31:0] SEED        = CHK_SEED_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    and_check_engine_if.master bus
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
    localparam logic [15:0]          LAST_VEC = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]           LAST_DRN = 4'(DUT_LATENCY - 1);

`ifdef CHK_FIRST_ERR_EN
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } line_t;
`else
    typedef struct packed {
        logic [WIDTH-1:0] exp;
    } line_t;
`endif

    state_t               state, state_nx;
    logic [31:0]          lfsr;
    logic                 start_ok, lfsr_adv;
    logic [15:0]          vec_cnt;
    logic [3:0]           drn_cnt;
    line_t                line_in, line_out;
    logic                 vld_in, vld_out, mismatch;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic                 pass_q;

    and_chk_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_ok),
        .advance (lfsr_adv),
        .state   (lfsr)
    );

    // Only the low WIDTH bits of each 16-bit half feed the operands.
    wire unused_lfsr = ^lfsr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        lfsr_adv = 1'b0;
        case (state)
            IDLE:  if (bus.start) begin
                       start_ok = 1'b1;
                       state_nx = RUN;
                   end
            RUN:   begin
                       lfsr_adv = 1'b1;
                       if (vec_cnt == LAST_VEC)
                           state_nx = (DUT_LATENCY == 0) ? DONE : DRAIN;
                   end
            DRAIN: if (drn_cnt == LAST_DRN) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign vld_in      = (state == RUN);
    assign bus.a       = vld_in ? lfsr[WIDTH-1:0]   : '0;
    assign bus.b       = vld_in ? lfsr[WIDTH+15:16] : '0;
    assign bus.busy    = (state == RUN) || (state == DRAIN);
    assign bus.done    = (state == DONE);
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_cnt;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            vec_cnt <= '0;
            drn_cnt <= '0;
        end else begin
            if (state == RUN)   vec_cnt <= vec_cnt + 16'd1;
            if (state == DRAIN) drn_cnt <= drn_cnt + 4'd1;
        end
    end

    always_comb begin
        line_in     = '0;
        line_in.exp = bus.a & bus.b;
`ifdef CHK_FIRST_ERR_EN
        line_in.a   = bus.a;
        line_in.b   = bus.b;
`endif
    end

    // Expected values wait DUT_LATENCY cycles so they line up with c.
    generate
        if (DUT_LATENCY == 0) begin : g_lat0
            assign line_out = line_in;
            assign vld_out  = vld_in;
        end else begin : g_line
            line_t                  line_q [DUT_LATENCY];
            logic [DUT_LATENCY-1:0] vld_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= vld_in;
                    for (int k = 1; k < DUT_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
                end
            end

            always_ff @(posedge clk) begin
                line_q[0] <= line_in;
                for (int k = 1; k < DUT_LATENCY; k++) line_q[k] <= line_q[k-1];
            end

            assign line_out = line_q[DUT_LATENCY-1];
            assign vld_out  = vld_pipe[DUT_LATENCY-1];
        end
    endgenerate

    assign mismatch = vld_out && (bus.c != line_out.exp);

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_cnt <= '0;
            pass_q  <= 1'b0;
        end else begin
            if (mismatch && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + ERR_CNT_W'(1);
            if (state == DONE) pass_q <= (err_cnt == '0);
        end
    end

`ifdef CHK_FIRST_ERR_EN
    logic [3*WIDTH-1:0] first_err;

    // A zero count marks the first mismatch; saturation never returns it to zero.
    always_ff @(posedge clk) begin
        if (rst || start_ok)
            first_err <= '0;
        else if (mismatch && (err_cnt == '0))
            first_err <= {line_out.a, line_out.b, bus.c};
    end

    assign bus.first_err = first_err;
`endif

endmodule

// File: tb/tb_and_check_engine.sv
// Bench for and_check_engine: engine A (latency 2, 8-bit count) and engine B (latency 0,
// 3-bit saturating count) drive a behavioural AND block with selectable faults.
module tb_and_check_engine;

    localparam int          W     = 8;
    localparam int          NV    = 16;
    localparam int          LAT_A = 2;
    localparam int          LAT_B = 0;
    localparam int          ECW_A = 8;
    localparam int          ECW_B = 3;
    localparam logic [31:0] SEED  = 32'h0000_ACE1;
    localparam logic [31:0] POLY  = 32'h8020_0003;

    typedef struct { int done_at; int err; bit pass; logic [3*W-1:0] ferr; } resp_t;
    typedef struct { int cyc_at; logic [W-1:0] a; logic [W-1:0] b; } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    and_check_engine_if #(.WIDTH(W), .ERR_CNT_W(ECW_A)) ifa ();
    and_check_engine_if #(.WIDTH(W), .ERR_CNT_W(ECW_B)) ifb ();

    and_check_engine #(.WIDTH(W), .NUM_VECTORS(NV), .DUT_LATENCY(LAT_A), .ERR_CNT_W(ECW_A), .SEED(SEED))
        u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    and_check_engine #(.WIDTH(W), .NUM_VECTORS(NV), .DUT_LATENCY(LAT_B), .ERR_CNT_W(ECW_B), .SEED(SEED))
        u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector sequence straight from the LFSR definition: a = low byte, b = byte at bit 16.
    logic [W-1:0] ref_a [NV];
    logic [W-1:0] ref_b [NV];

    function automatic void build_ref();
        logic [31:0] s;
        s = SEED;
        for (int i = 0; i < NV; i++) begin
            ref_a[i] = s[W-1:0];
            ref_b[i] = s[W+15:16];
            s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        end
    endfunction

    // Fault modes of the AND block: 0 ideal, 1 stuck at 0, 2 inverted, 3 flip bit 0 on a tagged vector.
    function automatic logic [W-1:0] fault(input int mode, input logic [W-1:0] v, input logic tag);
        case (mode)
            1:       return '0;
            2:       return ~v;
            3:       return tag ? (v ^ W'(1)) : v;
            default: return v;
        endcase
    endfunction

    int           mode_a = 0, mode_b = 0, fidx = 5, run_cyc = 0;
    logic [W-1:0] pa1 = '0, pa2 = '0;
    logic         ta1 = 1'b0, ta2 = 1'b0;

    always @(posedge clk) begin
        run_cyc <= ifa.start ? 0 : run_cyc + 1;
        pa1     <= ifa.a & ifa.b;
        pa2     <= pa1;
        ta1     <= (run_cyc == fidx);
        ta2     <= ta1;
    end

    assign ifa.c = fault(mode_a, pa2, ta2);
    assign ifb.c = fault(mode_b, ifb.a & ifb.b, 1'b0);

    function automatic resp_t expect_run(input int mode, input int lat, input int ecw, input int k, input int c0);
        resp_t        r;
        int           errs;
        logic [W-1:0] v, cb;
        errs   = 0;
        r.ferr = '0;
        for (int i = 0; i < NV; i++) begin
            v  = ref_a[i] & ref_b[i];
            cb = fault(mode, v, i == k);
            if (cb != v) begin
                if (errs == 0) r.ferr = {ref_a[i], ref_b[i], cb};
                errs++;
            end
        end
        r.err     = (errs > (1 << ecw) - 1) ? (1 << ecw) - 1 : errs;
        r.pass    = (errs == 0);
        r.done_at = c0 + NV + lat + 1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    resp_t qa[$], qb[$];
    vec_t  va[$], vb[$];
    resp_t pend_a, pend_b;
    vec_t  mv_a, mv_b;
    bit    chk_pa = 1'b0, chk_pb = 1'b0;

    always @(negedge clk) if (!rst) begin
        if (chk_pa) begin
            chk("pass_a", 64'(ifa.pass), 64'(pend_a.pass));
`ifdef CHK_FIRST_ERR_EN
            chk("first_err_a", 64'(ifa.first_err), 64'(pend_a.ferr));
`endif
            chk_pa = 1'b0;
        end
        if (va.size() > 0 && va[0].cyc_at == cyc) begin
            mv_a = va.pop_front();
            chk("a_vec_a", 64'(ifa.a), 64'(mv_a.a));
            chk("b_vec_a", 64'(ifa.b), 64'(mv_a.b));
        end else begin
            chk("a_idle_a", 64'(ifa.a), 64'd0);
            chk("b_idle_a", 64'(ifa.b), 64'd0);
        end
        if (ifa.done) begin
            if (qa.size() == 0) chk("done_unexpected_a", 64'(ifa.done), 64'd0);
            else begin
                pend_a = qa.pop_front();
                chk("done_cycle_a", 64'(cyc), 64'(pend_a.done_at));
                chk("err_cnt_a", 64'(ifa.err_cnt), 64'(pend_a.err));
                chk_pa = 1'b1;
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        if (chk_pb) begin
            chk("pass_b", 64'(ifb.pass), 64'(pend_b.pass));
`ifdef CHK_FIRST_ERR_EN
            chk("first_err_b", 64'(ifb.first_err), 64'(pend_b.ferr));
`endif
            chk_pb = 1'b0;
        end
        if (vb.size() > 0 && vb[0].cyc_at == cyc) begin
            mv_b = vb.pop_front();
            chk("a_vec_b", 64'(ifb.a), 64'(mv_b.a));
            chk("b_vec_b", 64'(ifb.b), 64'(mv_b.b));
        end else begin
            chk("a_idle_b", 64'(ifb.a), 64'd0);
            chk("b_idle_b", 64'(ifb.b), 64'd0);
        end
        if (ifb.done) begin
            if (qb.size() == 0) chk("done_unexpected_b", 64'(ifb.done), 64'd0);
            else begin
                pend_b = qb.pop_front();
                chk("done_cycle_b", 64'(cyc), 64'(pend_b.done_at));
                chk("err_cnt_b", 64'(ifb.err_cnt), 64'(pend_b.err));
                chk_pb = 1'b1;
            end
        end
    end

    task automatic start_run(input bit on_b, input int mode, input int k);
        resp_t r;
        vec_t  v;
        @(posedge clk); #1;
        if (on_b) begin
            mode_b    = mode;
            ifb.start = 1'b1;
        end else begin
            mode_a    = mode;
            fidx      = k;
            ifa.start = 1'b1;
        end
        r = expect_run(mode, on_b ? LAT_B : LAT_A, on_b ? ECW_B : ECW_A, k, cyc);
        if (on_b) qb.push_back(r); else qa.push_back(r);
        for (int i = 0; i < NV; i++) begin
            v.cyc_at = cyc + 1 + i;
            v.a      = ref_a[i];
            v.b      = ref_b[i];
            if (on_b) vb.push_back(v); else va.push_back(v);
        end
        @(posedge clk); #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic wait_runs(input int budget);
        int n;
        n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || chk_pa || chk_pb) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: %0d runs still pending after %0d cycles, expected 0",
                     qa.size() + qb.size(), budget);
            qa.delete(); qb.delete(); va.delete(); vb.delete();
            chk_pa = 1'b0;
            chk_pb = 1'b0;
        end
        repeat (2 + $urandom_range(0, 3)) @(posedge clk);
    endtask

    initial begin
        int m;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        build_ref();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy_a", 64'(ifa.busy), 64'd0);
        chk("rst_done_a", 64'(ifa.done), 64'd0);
        chk("rst_pass_a", 64'(ifa.pass), 64'd0);
        chk("rst_err_a",  64'(ifa.err_cnt), 64'd0);
        chk("rst_busy_b", 64'(ifb.busy), 64'd0);
        chk("rst_err_b",  64'(ifb.err_cnt), 64'd0);
`ifdef CHK_FIRST_ERR_EN
        chk("rst_first_err_a", 64'(ifa.first_err), 64'd0);
`endif

        start_run(0, 0, 0); wait_runs(100);
        start_run(0, 1, 0); wait_runs(100);
        start_run(0, 3, 5); wait_runs(100);
        start_run(0, 3, int'($urandom_range(0, NV - 1))); wait_runs(100);
        start_run(0, 2, 0); wait_runs(100);

        // Reset in the middle of a run, then a clean rerun must repeat the first sequence.
        start_run(0, 0, 0);
        repeat ($urandom_range(3, 8)) @(posedge clk);
        #1 rst = 1'b1;
        qa.delete();
        va.delete();
        chk_pa = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy_a", 64'(ifa.busy), 64'd0);
        chk("midrst_done_a", 64'(ifa.done), 64'd0);
        chk("midrst_err_a",  64'(ifa.err_cnt), 64'd0);
        chk("midrst_a_a",    64'(ifa.a), 64'd0);
        chk("midrst_b_a",    64'(ifa.b), 64'd0);
        start_run(0, 0, 0); wait_runs(100);

        // Start pulses in RUN and in DONE must be ignored.
        start_run(1, 0, 0);
        repeat (2) @(posedge clk); #1 ifb.start = 1'b1;
        @(posedge clk); #1 ifb.start = 1'b0;
        repeat (NV - 3) @(posedge clk); #1 ifb.start = 1'b1;
        @(posedge clk); #1 ifb.start = 1'b0;
        wait_runs(100);

        start_run(1, 2, 0); wait_runs(100);
        start_run(1, 1, 0); wait_runs(100);

        for (int i = 0; i < 6; i++) begin
            m = i[0] ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
            start_run(i[0], m, int'($urandom_range(0, NV - 1)));
            wait_runs(100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
